// File: rtl/seven_seg_scan_decoder_if.sv
// Multiplexed seven-segment scan bus: active-low segments and active-low anodes.
// The display driver is the master; the scan decoder samples it as the slave.
interface seven_seg_scan_decoder_if;
    logic [6:0] seg_vector;
    logic       a1;
    logic       a2;
    logic       a3;
    logic       a4;

    modport master (output seg_vector, a1, a2, a3, a4);
    modport slave  (input  seg_vector, a1, a2, a3, a4);
endinterface

// File: rtl/seven_seg_scan_decoder.sv
// Receive-side monitor for a four-digit multiplexed seven-segment scan.
// Decodes lit digits back to BCD, assembles 1-2-3-4 frames, and tracks blanking and protocol errors.
module seven_seg_scan_decoder #(
    parameter int DARK_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    seven_seg_scan_decoder_if.slave       bus,
    output logic [3:0]                    val1,
    output logic [3:0]                    val2,
    output logic [3:0]                    val3,
    output logic [3:0]                    val4,
    output logic [13:0]                   value,
    output logic                          frame_valid,
    output logic                          blank,
    output logic [7:0]                    blink_count,
    output logic                          err,
    output logic [7:0]                    err_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GOT1 = 2'd1,
        GOT2 = 2'd2,
        GOT3 = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [3:0]  anodes;
    logic        seg_legal;
    logic [3:0]  seg_bcd;
    logic        one_low;
    logic [1:0]  pos;
    logic        is_digit;
    logic        is_dark;
    logic        is_error;

    logic        load1;
    logic        load2;
    logic        load3;
    logic        commit;

    logic [3:0]  sh1;
    logic [3:0]  sh2;
    logic [3:0]  sh3;
    logic [13:0] commit_value;
    logic [7:0]  dark_run;

    assign anodes = {bus.a1, bus.a2, bus.a3, bus.a4};

    always_comb begin
        seg_legal = 1'b1;
        seg_bcd   = 4'd0;
        case (bus.seg_vector)
            7'b0000001: seg_bcd = 4'd0;
            7'b1001111: seg_bcd = 4'd1;
            7'b0010010: seg_bcd = 4'd2;
            7'b0000110: seg_bcd = 4'd3;
            7'b1001100: seg_bcd = 4'd4;
            7'b0100100: seg_bcd = 4'd5;
            7'b0100000: seg_bcd = 4'd6;
            7'b0001111: seg_bcd = 4'd7;
            7'b0000000: seg_bcd = 4'd8;
            7'b0000100: seg_bcd = 4'd9;
            default:    seg_legal = 1'b0;
        endcase
    end

    // pos is zero-based: 0 means the thousands anode a1 is the one pulled low.
    always_comb begin
        one_low = 1'b1;
        pos     = 2'd0;
        case (anodes)
            4'b0111: pos = 2'd0;
            4'b1011: pos = 2'd1;
            4'b1101: pos = 2'd2;
            4'b1110: pos = 2'd3;
            default: one_low = 1'b0;
        endcase
        is_digit = one_low && seg_legal;
        is_dark  = (anodes == 4'b1111) && (bus.seg_vector == 7'b1111111);
        is_error = !is_digit && !is_dark;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = IDLE;
        if (is_digit) begin
            if (pos == 2'd0) begin
                state_next = GOT1;
            end else if (state == GOT1 && pos == 2'd1) begin
                state_next = GOT2;
            end else if (state == GOT2 && pos == 2'd2) begin
                state_next = GOT3;
            end
        end
    end

    always_comb begin
        load1  = is_digit && (pos == 2'd0);
        load2  = is_digit && (state == GOT1) && (pos == 2'd1);
        load3  = is_digit && (state == GOT2) && (pos == 2'd2);
        commit = is_digit && (state == GOT3) && (pos == 2'd3);
    end

    // The ones digit comes straight from the current cycle so the commit lands on the DIGIT(4) edge.
    assign commit_value = 14'(sh1) * 14'd1000 + 14'(sh2) * 14'd100
                        + 14'(sh3) * 14'd10 + 14'(seg_bcd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh1 <= 4'd0;
            sh2 <= 4'd0;
            sh3 <= 4'd0;
        end else if (is_dark) begin
            sh1 <= 4'd0;
            sh2 <= 4'd0;
            sh3 <= 4'd0;
        end else begin
            if (load1) sh1 <= seg_bcd;
            if (load2) sh2 <= seg_bcd;
            if (load3) sh3 <= seg_bcd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val1        <= 4'd0;
            val2        <= 4'd0;
            val3        <= 4'd0;
            val4        <= 4'd0;
            value       <= 14'd0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= commit;
            if (commit) begin
                val1  <= sh1;
                val2  <= sh2;
                val3  <= sh3;
                val4  <= seg_bcd;
                value <= commit_value;
            end
        end
    end

    // Errors reset the dark run but leave blank alone; only a lit digit ends a blank interval.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dark_run    <= 8'd0;
            blank       <= 1'b0;
            blink_count <= 8'd0;
        end else if (is_dark) begin
            if (dark_run < 8'(DARK_CYCLES)) begin
                dark_run <= dark_run + 8'd1;
            end
            if (({1'b0, dark_run} + 9'd1 >= 9'(DARK_CYCLES)) && !blank) begin
                blank <= 1'b1;
                if (blink_count != 8'd255) begin
                    blink_count <= blink_count + 8'd1;
                end
            end
        end else if (is_digit) begin
            dark_run <= 8'd0;
            blank    <= 1'b0;
        end else begin
            dark_run <= 8'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err       <= 1'b0;
            err_count <= 8'd0;
        end else begin
            err <= is_error;
            if (is_error && err_count != 8'd255) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Self-checking bench for seven_seg_scan_decoder: drives scan cycles, queues expected frames
// and compares them with the frames the decoder commits.
module tb_seven_seg_scan_decoder;

    typedef struct packed {
        logic [3:0]  v1;
        logic [3:0]  v2;
        logic [3:0]  v3;
        logic [3:0]  v4;
        logic [13:0] value;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  val1, val2, val3, val4;
    logic [13:0] value;
    logic        frame_valid;
    logic        blank;
    logic [7:0]  blink_count;
    logic        err;
    logic [7:0]  err_count;

    int n_compared   = 0;
    int n_mismatched = 0;

    frame_t exp_q[$];
    frame_t obs_q[$];

    logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    seven_seg_scan_decoder_if bus ();

    seven_seg_scan_decoder #(.DARK_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .val1        (val1),
        .val2        (val2),
        .val3        (val3),
        .val4        (val4),
        .value       (value),
        .frame_valid (frame_valid),
        .blank       (blank),
        .blink_count (blink_count),
        .err         (err),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    // Collect every committed frame shortly after the edge that produced it.
    always @(posedge clk) begin
        #1;
        if (frame_valid === 1'b1) obs_q.push_back({val1, val2, val3, val4, value});
    end

    // One scan cycle: inputs change 2 time units after an edge and are sampled at the next edge.
    task automatic step(input logic [3:0] an, input logic [6:0] seg);
        bus.a1 = an[3];
        bus.a2 = an[2];
        bus.a3 = an[1];
        bus.a4 = an[0];
        bus.seg_vector = seg;
        @(posedge clk);
        #2;
    endtask

    task automatic send_digit(input int p, input int d);
        logic [3:0] an;
        an = 4'b1000 >> (p - 1);
        step(~an, seg_tab[d]);
    endtask

    task automatic push_exp(input int d1, input int d2, input int d3, input int d4);
        frame_t f;
        f.v1 = 4'(d1);
        f.v2 = 4'(d2);
        f.v3 = 4'(d3);
        f.v4 = 4'(d4);
        f.value = 14'(d1 * 1000 + d2 * 100 + d3 * 10 + d4);
        exp_q.push_back(f);
    endtask

    task automatic send_frame(input int d1, input int d2, input int d3, input int d4);
        push_exp(d1, d2, d3, d4);
        send_digit(1, d1);
        send_digit(2, d2);
        send_digit(3, d3);
        send_digit(4, d4);
    endtask

    task automatic test_reset();
        n_compared++;
        if ({val1, val2, val3, val4} !== 16'h0000) begin
            n_mismatched++;
            $display("[TB] FAIL reset_vals got %h want 0000", {val1, val2, val3, val4});
        end
        n_compared++;
        if (value !== 14'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_value got %0d want 0", value);
        end
        n_compared++;
        if ({frame_valid, blank, err} !== 3'b000) begin
            n_mismatched++;
            $display("[TB] FAIL reset_flags got %b want 000", {frame_valid, blank, err});
        end
        n_compared++;
        if ({blink_count, err_count} !== 16'h0000) begin
            n_mismatched++;
            $display("[TB] FAIL reset_counts got %h want 0000", {blink_count, err_count});
        end
    endtask

    task automatic test_continuous();
        int digs [4] = '{0, 1, 5, 0};
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 4; k++) begin
                if (k == 3) push_exp(0, 1, 5, 0);
                send_digit(k + 1, digs[k]);
                n_compared++;
                if (frame_valid !== (k == 3)) begin
                    n_mismatched++;
                    $display("[TB] FAIL cont_fv frame %0d pos %0d got %b want %b", f, k + 1, frame_valid, k == 3);
                end
                n_compared++;
                if (err !== 1'b0) begin
                    n_mismatched++;
                    $display("[TB] FAIL cont_err got %b want 0", err);
                end
            end
        end
        n_compared++;
        if (value !== 14'd150) begin
            n_mismatched++;
            $display("[TB] FAIL cont_value got %0d want 150", value);
        end
        n_compared++;
        if (obs_q.size() != exp_q.size()) begin
            n_mismatched++;
            $display("[TB] FAIL cont_frames got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            frame_t e = exp_q.pop_front();
            frame_t o = obs_q.pop_front();
            n_compared++;
            if (o !== e) begin
                n_mismatched++;
                $display("[TB] FAIL cont_frame got %h want %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_blank();
        for (int f = 0; f < 3; f++) send_frame(9, 9, 9, 9);
        for (int i = 0; i < 8; i++) begin
            step(4'b1111, 7'b1111111);
            n_compared++;
            if (blank !== (i >= 3)) begin
                n_mismatched++;
                $display("[TB] FAIL blank_rise dark %0d got %b want %b", i + 1, blank, i >= 3);
            end
            n_compared++;
            if (blink_count !== ((i >= 3) ? 8'd1 : 8'd0)) begin
                n_mismatched++;
                $display("[TB] FAIL blink_count dark %0d got %0d want %0d", i + 1, blink_count, (i >= 3) ? 1 : 0);
            end
            n_compared++;
            if (value !== 14'd9999 || {val1, val2, val3, val4} !== 16'h9999) begin
                n_mismatched++;
                $display("[TB] FAIL blank_hold got %0d/%h want 9999", value, {val1, val2, val3, val4});
            end
        end
        push_exp(0, 0, 1, 6);
        send_digit(1, 0);
        n_compared++;
        if (blank !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL blank_fall got %b want 0", blank);
        end
        send_digit(2, 0);
        send_digit(3, 1);
        send_digit(4, 6);
        n_compared++;
        if (value !== 14'd16) begin
            n_mismatched++;
            $display("[TB] FAIL blank_value got %0d want 16", value);
        end
        n_compared++;
        if (obs_q.size() != exp_q.size()) begin
            n_mismatched++;
            $display("[TB] FAIL blank_frames got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            frame_t e = exp_q.pop_front();
            frame_t o = obs_q.pop_front();
            n_compared++;
            if (o !== e) begin
                n_mismatched++;
                $display("[TB] FAIL blank_frame got %h want %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_error_pattern();
        send_digit(1, 4);
        step(4'b1011, 7'b1111110);
        n_compared++;
        if (err !== 1'b1 || err_count !== 8'd1) begin
            n_mismatched++;
            $display("[TB] FAIL badseg_err got %b/%0d want 1/1", err, err_count);
        end
        send_digit(3, 2);
        n_compared++;
        if (err !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL badseg_pulse got %b want 0", err);
        end
        send_digit(4, 7);
        n_compared++;
        if (obs_q.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL badseg_nocommit got %0d frames want 0", obs_q.size());
        end
        send_frame(8, 3, 6, 2);
        n_compared++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            n_mismatched++;
            $display("[TB] FAIL badseg_frames got %0d want 1", obs_q.size());
        end else begin
            frame_t e = exp_q.pop_front();
            frame_t o = obs_q.pop_front();
            n_compared++;
            if (o !== e) begin
                n_mismatched++;
                $display("[TB] FAIL badseg_frame got %h want %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_multi_anode();
        send_digit(1, 1);
        send_digit(2, 2);
        step(4'b0101, seg_tab[3]);
        n_compared++;
        if (err !== 1'b1 || err_count !== 8'd2) begin
            n_mismatched++;
            $display("[TB] FAIL multi_err got %b/%0d want 1/2", err, err_count);
        end
        send_digit(3, 3);
        send_digit(4, 4);
        n_compared++;
        if (obs_q.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL multi_idle got %0d frames want 0", obs_q.size());
        end
        step(4'b1111, 7'b0111111);
        n_compared++;
        if (err !== 1'b1 || err_count !== 8'd3) begin
            n_mismatched++;
            $display("[TB] FAIL darkseg_err got %b/%0d want 1/3", err, err_count);
        end
        send_frame(5, 6, 7, 8);
        n_compared++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            n_mismatched++;
            $display("[TB] FAIL multi_frames got %0d want 1", obs_q.size());
        end else begin
            frame_t e = exp_q.pop_front();
            frame_t o = obs_q.pop_front();
            n_compared++;
            if (o !== e) begin
                n_mismatched++;
                $display("[TB] FAIL multi_frame got %h want %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_out_of_order();
        int seq [6] = '{3, 4, 1, 2, 3, 4};
        for (int i = 0; i < 6; i++) begin
            if (i == 5) push_exp(1, 2, 3, 4);
            send_digit(seq[i], seq[i]);
            n_compared++;
            if (frame_valid !== (i == 5) || err !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL ooo_step %0d got fv=%b err=%b want fv=%b err=0", i, frame_valid, err, i == 5);
            end
        end
        send_digit(1, 9);
        send_digit(2, 9);
        send_digit(2, 9);
        send_digit(3, 9);
        send_digit(4, 9);
        n_compared++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            n_mismatched++;
            $display("[TB] FAIL ooo_frames got %0d want 1", obs_q.size());
        end else begin
            frame_t e = exp_q.pop_front();
            frame_t o = obs_q.pop_front();
            n_compared++;
            if (o !== e) begin
                n_mismatched++;
                $display("[TB] FAIL ooo_frame got %h want %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset_mid();
        send_frame(0, 3, 0, 0);
        n_compared++;
        if (value !== 14'd300) begin
            n_mismatched++;
            $display("[TB] FAIL rst_pre_value got %0d want 300", value);
        end
        send_digit(1, 0);
        send_digit(2, 1);
        #2;
        rst = 1'b1;
        #1;
        n_compared++;
        if ({val1, val2, val3, val4, value} !== 30'd0 || {frame_valid, blank, err} !== 3'b000
            || {blink_count, err_count} !== 16'h0000) begin
            n_mismatched++;
            $display("[TB] FAIL rst_async got vals=%h value=%0d blink=%0d errs=%0d want all 0",
                     {val1, val2, val3, val4}, value, blink_count, err_count);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        exp_q.delete();
        obs_q.delete();
        send_digit(3, 8);
        send_digit(4, 0);
        n_compared++;
        if (obs_q.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL rst_partial got %0d frames want 0", obs_q.size());
        end
        send_frame(0, 1, 8, 0);
        n_compared++;
        if (value !== 14'd180) begin
            n_mismatched++;
            $display("[TB] FAIL rst_post_value got %0d want 180", value);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_err_saturate();
        for (int i = 0; i < 300; i++) step(4'b0000, 7'b0000000);
        n_compared++;
        if (err_count !== 8'd255) begin
            n_mismatched++;
            $display("[TB] FAIL err_sat got %0d want 255", err_count);
        end
        step(4'b1111, 7'b1111110);
        n_compared++;
        if (err_count !== 8'd255 || err !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL err_sat_hold got %0d/%b want 255/1", err_count, err);
        end
    endtask

    initial begin
        bus.a1 = 1'b1;
        bus.a2 = 1'b1;
        bus.a3 = 1'b1;
        bus.a4 = 1'b1;
        bus.seg_vector = 7'b1111111;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        test_reset();
        test_continuous();
        test_blank();
        test_error_pattern();
        test_multi_anode();
        test_out_of_order();
        test_reset_mid();
        test_err_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_decoder.md
# seven_seg_scan_decoder

Receive-side monitor for the four-digit multiplexed seven-segment bus (active-low segments `seg_vector[6:0]` plus active-low anodes `a1..a4`) that the parking meter display path drives. It samples the scan every clock and decodes each lit digit back to BCD. It assembles complete 1-2-3-4 frames, publishes the recovered digits and binary value, and detects blanking (blink) intervals and protocol errors. It sits in the verification/self-check path and on the board-level loopback between the display driver and the status logic.

## Interface
- `DARK_CYCLES`, 4: consecutive all-dark cycles required to declare the display blank; range 2..255.
- `clk`  in  1  system clock; all inputs are sampled on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `seg_vector`  in  7  active-low segments; bit6=a … bit0=g.
- `a1`, `a2`, `a3`, `a4`  in  1 each  active-low anode enables; `a1` is the thousands digit.
- `val1`, `val2`, `val3`, `val4`  out  4 each  last committed BCD digits (thousands..ones).
- `value`  out  14  last committed value: val1*1000 + val2*100 + val3*10 + val4.
- `frame_valid`  out  1  one-cycle pulse when a new frame commits.
- `blank`  out  1  display currently dark.
- `blink_count`  out  8  count of blank rising edges; saturates at 255.
- `err`  out  1  one-cycle pulse on a protocol error.
- `err_count`  out  8  count of errors; saturates at 255.

## Operation
- Per-cycle classification:
  - DIGIT(p): exactly one anode is low (position p) and `seg_vector` is one of the ten legal patterns. The legal patterns are 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - DARK: all anodes are high and `seg_vector`=1111111.
  - ERROR: anything else: two or more anodes low; one anode low with an illegal pattern; all anodes high with any segment low.
- Frame FSM, states IDLE, GOT1, GOT2, GOT3:
  - DIGIT(1) from any state loads shadow digit 1 and goes to GOT1.
  - DIGIT(2) in GOT1 goes to GOT2.
  - DIGIT(3) in GOT2 goes to GOT3.
  - DIGIT(4) in GOT3 commits the four shadow digits to `val1..val4`, loads `value`, pulses `frame_valid`, and goes to IDLE.
  - Any other DIGIT(p) is out of order: go to IDLE with no error. DIGIT(1) is the only exception, as above.
  - DARK goes to IDLE and discards the shadow digits.
  - ERROR goes to IDLE, pulses `err`, and increments `err_count`.
- A repeated position, such as DIGIT(2) twice, counts as out of order and goes to IDLE.
- Dark run counter: 8 bits. It increments on DARK, saturating at `DARK_CYCLES`, and clears on DIGIT or ERROR.
  - `blank` sets on the edge where the counter reaches `DARK_CYCLES`. On the 0→1 transition, `blink_count` increments.
  - `blank` clears on the first DIGIT cycle. ERROR cycles do not clear `blank`.
- `value` arithmetic: computed from the shadow digits in 14 bits at commit; the maximum is 9999. Shift-add is acceptable; the result must be registered.
- Committed outputs hold their values until the next commit. Blanking does not alter `val*` or `value`.

## Timing
- Reset values: `val1..val4`=0, `value`=0, `frame_valid`=0, `blank`=0, `blink_count`=0, `err`=0, `err_count`=0, FSM=IDLE, dark run=0.
- All outputs are registered.
- If the DIGIT(4) cycle is sampled at edge N, `frame_valid`, `val*` and `value` change at edge N and are valid until edge N+1. `frame_valid` is high for exactly that one cycle.
- `err` is high for exactly one cycle after the edge that samples the ERROR cycle.
- `blank` rises at the edge that samples the `DARK_CYCLES`-th consecutive DARK cycle.
- Minimum frame is four consecutive cycles (1,2,3,4). Back-to-back frames therefore give `frame_valid` every 4 cycles.
- Asserting `rst` mid-frame immediately forces all reset values, including clearing already-committed outputs. The first commit after release requires a full 1-2-3-4 sequence.
- Counter saturation: at 255, increments are ignored with no wrap.

## Test plan
- Continuous scan of 0,1,5,0: `frame_valid` pulses every 4 cycles; `val1..4`=0,1,5,0; `value`=150; `err`=0.
- Scan 9999 for 3 frames, then 8 DARK cycles, then scan 0016, with `DARK_CYCLES`=4:
  - `blank` rises on the 4th dark cycle and `blink_count`=1.
  - During the dark cycles `val*`/`value` hold 9999.
  - `blank` falls on the first lit digit.
  - `value`=16 after the next full frame.
- Frame with pattern 1111110 at position 2:
  - `err` pulses once and `err_count`=1.
  - No `frame_valid` for that frame.
  - The next clean frame commits normally.
- Cycle with `a1`=`a3`=0: `err` pulse and FSM to IDLE. Separately, a cycle with all anodes high and seg=0111111 also raises `err`.
- Scan starting at position 3 (3,4,1,2,3,4): exactly one `frame_valid`, on the second position-4 cycle; no `err`.
- Assert `rst` during GOT2 after a committed `value`=300: all outputs return to 0 asynchronously. After release, a full frame of 0180 gives `value`=180. Separately, drive 300 erroneous cycles: `err_count` holds at 255.
